// File: rtl/cpu_imem_responder.sv
// Instruction-fetch responder: turns PC read requests into single Avalon-MM reads,
// returns the fetched word with a one-cycle valid pulse and stalls the CPU meanwhile.
// A PC redirect (flush) kills the outstanding read; its data is drained and dropped.
module cpu_imem_responder #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_pc_rd,
    input  logic [ADDR_W-1:0] i_pc_addr,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_pc_rddata,
    output logic              o_pc_valid,
    output logic              o_stall,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    input  logic              i_mem_waitrequest,
    input  logic [DATA_W-1:0] i_mem_rddata,
    input  logic              i_mem_rddatavalid
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrop} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_q, pend_d;
    logic              flush_seen_q, flush_seen_d;
    logic [DATA_W-1:0] rddata_q, rddata_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] req_addr;
    logic              redirect;

    // Instructions are halfword aligned, so bit 0 of the PC never reaches the bus.
    assign req_addr = {i_pc_addr[ADDR_W-1:1], 1'b0};
    assign redirect = i_flush & i_pc_rd;

    // Next-state and datapath decisions for the fetch FSM.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        pend_addr_d  = pend_addr_q;
        pend_d       = pend_q;
        flush_seen_d = flush_seen_q;
        rddata_d     = rddata_q;
        valid_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (i_pc_rd) begin
                    mem_addr_d = req_addr;
                    state_d    = StIssue;
                end
            end

            StIssue: begin
                // Read cannot be withdrawn while waitrequest is high; remember the flush.
                if (redirect) begin
                    pend_d      = 1'b1;
                    pend_addr_d = req_addr;
                end
                if (i_flush) begin
                    flush_seen_d = 1'b1;
                end
                if (!i_mem_waitrequest) begin
                    flush_seen_d = 1'b0;
                    state_d      = (flush_seen_q || i_flush) ? StDrop : StWait;
                end
            end

            StWait: begin
                if (i_mem_rddatavalid) begin
                    // Data landing with a flush belongs to the killed path.
                    if (!i_flush) begin
                        rddata_d = i_mem_rddata;
                        valid_d  = 1'b1;
                    end
                    // The read is complete either way, so a new request goes straight out.
                    if (i_pc_rd) begin
                        mem_addr_d = req_addr;
                        state_d    = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (i_flush) begin
                    state_d = StDrop;
                    if (i_pc_rd) begin
                        pend_d      = 1'b1;
                        pend_addr_d = req_addr;
                    end
                end
            end

            StDrop: begin
                // Last redirect wins, including one arriving with the drained data.
                if (redirect) begin
                    pend_d      = 1'b1;
                    pend_addr_d = req_addr;
                end
                if (i_mem_rddatavalid) begin
                    pend_d = 1'b0;
                    if (redirect) begin
                        mem_addr_d = req_addr;
                        state_d    = StIssue;
                    end else if (pend_q) begin
                        mem_addr_d = pend_addr_q;
                        state_d    = StIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StIdle;
            mem_addr_q   <= '0;
            pend_addr_q  <= '0;
            pend_q       <= 1'b0;
            flush_seen_q <= 1'b0;
            rddata_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            pend_addr_q  <= pend_addr_d;
            pend_q       <= pend_d;
            flush_seen_q <= flush_seen_d;
            rddata_q     <= rddata_d;
            valid_q      <= valid_d;
        end
    end

    // Stall drops in the cycle the fetched word is presented.
    always_comb begin
        o_stall     = (state_q != StIdle) && !valid_q;
        o_mem_read  = (state_q == StIssue);
        o_mem_addr  = mem_addr_q;
        o_pc_rddata = rddata_q;
        o_pc_valid  = valid_q;
    end

endmodule

// File: tb/tb_cpu_imem_responder.sv
// Directed bench for cpu_imem_responder: a transaction-level model (expected bus
// addresses and delivered words as queues, plus Avalon protocol invariants) is
// checked every cycle, alongside hand-computed cycle-exact expectations.
module tb_cpu_imem_responder;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_pc_rd;
    logic [ADDR_W-1:0] i_pc_addr;
    logic              i_flush;
    logic [DATA_W-1:0] o_pc_rddata;
    logic              o_pc_valid;
    logic              o_stall;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_read;
    logic              i_mem_waitrequest;
    logic [DATA_W-1:0] i_mem_rddata;
    logic              i_mem_rddatavalid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [DATA_W-1:0] exp_data[$];
    int                outstanding = 0;
    logic              hold_chk    = 1'b0;
    logic [ADDR_W-1:0] hold_addr   = '0;

    cpu_imem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_pc_rd           (i_pc_rd),
        .i_pc_addr         (i_pc_addr),
        .i_flush           (i_flush),
        .o_pc_rddata       (o_pc_rddata),
        .o_pc_valid        (o_pc_valid),
        .o_stall           (o_stall),
        .o_mem_addr        (o_mem_addr),
        .o_mem_read        (o_mem_read),
        .i_mem_waitrequest (i_mem_waitrequest),
        .i_mem_rddata      (i_mem_rddata),
        .i_mem_rddatavalid (i_mem_rddatavalid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Transaction model: every accepted read must match the next expected address,
    // every valid pulse the next expected word; protocol rules checked alongside.
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            outstanding = 0;
            hold_chk    = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_read", 32'(o_mem_read), 1);
                check("hold_addr", 32'(o_mem_addr), 32'(hold_addr));
            end
            if (o_pc_valid) begin
                check("valid_no_stall", 32'(o_stall), 0);
                if (exp_data.size() == 0) check("unexpected_valid", 32'(o_pc_valid), 0);
                else check("pc_rddata", 32'(o_pc_rddata), 32'(exp_data.pop_front()));
            end
            if (i_mem_rddatavalid && outstanding > 0) outstanding--;
            if (o_mem_read && !i_mem_waitrequest) begin
                check("one_outstanding", 32'(outstanding), 0);
                if (exp_addr.size() == 0) check("unexpected_read", 32'(o_mem_read), 0);
                else check("mem_addr", 32'(o_mem_addr), 32'(exp_addr.pop_front()));
                outstanding++;
            end
            hold_chk  = o_mem_read && i_mem_waitrequest;
            hold_addr = o_mem_addr;
        end
    end

    // Request a fetch from IDLE and walk it to WAIT with zero waitrequest.
    task automatic issue(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] bus_addr);
        i_pc_rd   = 1'b1;
        i_pc_addr = addr;
        exp_addr.push_back(bus_addr);
        step();
        check("issue_read", 32'(o_mem_read), 1);
        check("issue_addr", 32'(o_mem_addr), 32'(bus_addr));
        check("issue_stall", 32'(o_stall), 1);
        i_pc_rd = 1'b0;
        step();
        check("wait_read", 32'(o_mem_read), 0);
        check("wait_stall", 32'(o_stall), 1);
    endtask

    // Return data for the read in WAIT and check the delivery pulse.
    task automatic complete(input logic [DATA_W-1:0] data);
        i_mem_rddatavalid = 1'b1;
        i_mem_rddata      = data;
        exp_data.push_back(data);
        step();
        i_mem_rddatavalid = 1'b0;
        check("done_valid", 32'(o_pc_valid), 1);
        check("done_data", 32'(o_pc_rddata), 32'(data));
        check("done_stall", 32'(o_stall), 0);
        step();
        check("pulse_one_cycle", 32'(o_pc_valid), 0);
    endtask

    initial begin
        i_reset_n         = 1'b0;
        i_pc_rd           = 1'b0;
        i_pc_addr         = '0;
        i_flush           = 1'b0;
        i_mem_waitrequest = 1'b0;
        i_mem_rddata      = '0;
        i_mem_rddatavalid = 1'b0;
        step();
        step();
        check("rst_stall", 32'(o_stall), 0);
        check("rst_read", 32'(o_mem_read), 0);
        check("rst_valid", 32'(o_pc_valid), 0);
        check("rst_rddata", 32'(o_pc_rddata), 0);
        check("rst_addr", 32'(o_mem_addr), 0);
        i_reset_n = 1'b1;
        step();

        // Single fetch: read at N+1, valid at N+3.
        issue(16'h0010, 16'h0010);
        complete(16'hA5C3);

        // Waitrequest held for three cycles: request stable for four.
        i_pc_rd   = 1'b1;
        i_pc_addr = 16'h0022;
        exp_addr.push_back(16'h0022);
        step();
        i_pc_rd           = 1'b0;
        i_mem_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) i_mem_waitrequest = 1'b0;
            check("wr_read", 32'(o_mem_read), 1);
            check("wr_addr", 32'(o_mem_addr), 32'h0022);
            check("wr_stall", 32'(o_stall), 1);
            step();
        end
        check("wr_wait_read", 32'(o_mem_read), 0);
        complete(16'h5A5A);

        // Odd address is aligned down.
        issue(16'h0035, 16'h0034);
        complete(16'h0F0F);

        // Flush with a redirect in WAIT: old data dropped, redirect target fetched.
        issue(16'h0050, 16'h0050);
        i_flush   = 1'b1;
        i_pc_rd   = 1'b1;
        i_pc_addr = 16'h0100;
        exp_addr.push_back(16'h0100);
        step();
        i_flush = 1'b0;
        i_pc_rd = 1'b0;
        check("drop_stall", 32'(o_stall), 1);
        check("drop_read", 32'(o_mem_read), 0);
        step();
        i_mem_rddatavalid = 1'b1;
        i_mem_rddata      = 16'h1111;
        step();
        i_mem_rddatavalid = 1'b0;
        check("drop_no_valid", 32'(o_pc_valid), 0);
        check("drop_rddata_kept", 32'(o_pc_rddata), 32'h0F0F);
        check("redirect_read", 32'(o_mem_read), 1);
        check("redirect_addr", 32'(o_mem_addr), 32'h0100);
        step();
        complete(16'h2222);

        // Back-to-back: data and next request in the same cycle, no idle bubble.
        issue(16'h0004, 16'h0004);
        i_mem_rddatavalid = 1'b1;
        i_mem_rddata      = 16'h3333;
        i_pc_rd           = 1'b1;
        i_pc_addr         = 16'h0002;
        exp_data.push_back(16'h3333);
        exp_addr.push_back(16'h0002);
        step();
        i_mem_rddatavalid = 1'b0;
        i_pc_rd           = 1'b0;
        check("b2b_valid", 32'(o_pc_valid), 1);
        check("b2b_data", 32'(o_pc_rddata), 32'h3333);
        check("b2b_read", 32'(o_mem_read), 1);
        check("b2b_addr", 32'(o_mem_addr), 32'h0002);
        step();
        check("b2b_wait_valid", 32'(o_pc_valid), 0);
        complete(16'h4444);

        // Flush coinciding with data in WAIT: data discarded, back to idle.
        issue(16'h0060, 16'h0060);
        i_flush           = 1'b1;
        i_mem_rddatavalid = 1'b1;
        i_mem_rddata      = 16'hDEAD;
        step();
        i_flush           = 1'b0;
        i_mem_rddatavalid = 1'b0;
        check("fv_no_valid", 32'(o_pc_valid), 0);
        check("fv_stall", 32'(o_stall), 0);
        check("fv_rddata_kept", 32'(o_pc_rddata), 32'h4444);

        // Flush with redirect during a stalled ISSUE: read completes, then is dropped.
        i_pc_rd   = 1'b1;
        i_pc_addr = 16'h0080;
        exp_addr.push_back(16'h0080);
        step();
        i_mem_waitrequest = 1'b1;
        i_flush           = 1'b1;
        i_pc_addr         = 16'h0090;
        exp_addr.push_back(16'h0090);
        step();
        i_flush = 1'b0;
        i_pc_rd = 1'b0;
        step();
        i_mem_waitrequest = 1'b0;
        step();
        check("idrop_read", 32'(o_mem_read), 0);
        check("idrop_stall", 32'(o_stall), 1);
        i_mem_rddatavalid = 1'b1;
        i_mem_rddata      = 16'h1234;
        step();
        i_mem_rddatavalid = 1'b0;
        check("idrop_no_valid", 32'(o_pc_valid), 0);
        check("idrop_redirect_addr", 32'(o_mem_addr), 32'h0090);
        step();
        complete(16'h5678);

        // Asynchronous reset mid-WAIT, then a stray late rddatavalid.
        issue(16'h0070, 16'h0070);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("areset_stall", 32'(o_stall), 0);
        check("areset_read", 32'(o_mem_read), 0);
        check("areset_valid", 32'(o_pc_valid), 0);
        step();
        i_reset_n         = 1'b1;
        i_mem_rddatavalid = 1'b1;
        i_mem_rddata      = 16'hBEEF;
        step();
        i_mem_rddatavalid = 1'b0;
        check("late_no_valid", 32'(o_pc_valid), 0);
        check("late_rddata", 32'(o_pc_rddata), 0);
        check("late_stall", 32'(o_stall), 0);
        step();

        check("addr_queue_drained", 32'(exp_addr.size()), 0);
        check("data_queue_drained", 32'(exp_data.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
